// File: rtl/data_mem_access_ctrl.sv
// data_mem_access_ctrl
// MEM-stage initiator for the data RAM port. Accepts one load/store request at a
// time, holds the RAM access for WAIT_STATES+1 cycles, then returns one aligned,
// extended response. Byte order is big-endian (addr[1:0]=0 -> bits [31:24], sel[3]).
// Optional feature macro: MEM_ALIGN_CHECK_EN (reject misaligned / reserved-size
// requests at acceptance with rsp_err=1 and no RAM access).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | ready for a request, RAM outputs idle
// S_ACCESS | RAM access in progress, cnt counts held cycles
// S_RESP   | response presented, waiting for rsp_ready
module data_mem_access_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_sel,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_STATES);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              lat_we;
  logic              lat_signed;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              req_err;
  logic              in_access;
  logic              access_done;
  logic [3:0]        sel_c;
  logic [31:0]       wdata_c;
  logic [31:0]       load_data;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;

  // Alignment/reserved-size check on the live request, evaluated at acceptance.
  always_comb begin
`ifdef MEM_ALIGN_CHECK_EN
    req_err = (req_size == 2'b11) ||
              ((req_size == 2'b01) && req_addr[0]) ||
              ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    req_err = 1'b0;
`endif
  end

  assign in_access   = (state_q == S_ACCESS);
  assign access_done = in_access && (cnt_q == CNT_LAST);

  // State register; async reset drops any access in flight without a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid) state_d = req_err ? S_RESP : S_ACCESS;
      S_ACCESS: if (access_done) state_d = S_RESP;
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Request latch, held-cycle counter and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      lat_we     <= 1'b0;
      lat_signed <= 1'b0;
      lat_size   <= 2'b00;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            cnt_q      <= '0;
            lat_we     <= req_we;
            lat_signed <= req_signed;
            lat_size   <= req_size;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            rdata_q    <= '0;
            err_q      <= req_err;
          end
        end
        S_ACCESS: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (access_done) begin
            rdata_q <= lat_we ? 32'h0 : load_data;
            err_q   <= 1'b0;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  // Byte-lane enables and lane-replicated store data from the latched request.
  // Without the alignment check, half ignores addr[0] and word/reserved ignore addr[1:0].
  always_comb begin
    sel_c   = 4'b1111;
    wdata_c = lat_wdata;
    case (lat_size)
      2'b00: begin
        sel_c   = 4'b1000 >> lat_addr[1:0];
        wdata_c = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        sel_c   = lat_addr[1] ? 4'b0011 : 4'b1100;
        wdata_c = {2{lat_wdata[15:0]}};
      end
      default: begin
        sel_c   = 4'b1111;
        wdata_c = lat_wdata;
      end
    endcase
  end

  // Load alignment: pick the addressed lane, move it to bit 0, then extend.
  always_comb begin
    load_byte = ram_rdata[31:24];
    case (lat_addr[1:0])
      2'd0:    load_byte = ram_rdata[31:24];
      2'd1:    load_byte = ram_rdata[23:16];
      2'd2:    load_byte = ram_rdata[15:8];
      default: load_byte = ram_rdata[7:0];
    endcase
    load_half = lat_addr[1] ? ram_rdata[15:0] : ram_rdata[31:16];
    case (lat_size)
      2'b00:   load_data = {{24{lat_signed & load_byte[7]}}, load_byte};
      2'b01:   load_data = {{16{lat_signed & load_half[15]}}, load_half};
      default: load_data = ram_rdata;
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign ram_ce    = in_access;
  assign ram_we    = in_access & lat_we;
  assign ram_addr  = in_access ? {lat_addr[ADDR_W-1:2], 2'b00} : '0;
  assign ram_sel   = in_access ? sel_c : 4'b0000;
  assign ram_wdata = in_access ? wdata_c : 32'h0;

endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Self-checking bench for data_mem_access_ctrl: directed cases plus randomized
// load/store traffic against a byte-array memory model (big-endian).
`timescale 1ns/1ps
module tb_data_mem_access_ctrl;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ram_ce;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [3:0]  ram_sel;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mem_b [64];
  logic [31:0] ram_w [16];
  logic [31:0] rd_got;

  data_mem_access_ctrl #(.ADDR_W(32), .WAIT_STATES(WS), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM: loads its contents from the byte model while reset is held.
  assign ram_rdata = ram_w[ram_addr[5:2]];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++)
        ram_w[i] <= {mem_b[4*i], mem_b[4*i+1], mem_b[4*i+2], mem_b[4*i+3]};
    end else if (ram_ce && ram_we) begin
      for (int l = 0; l < 4; l++)
        if (ram_sel[l]) ram_w[ram_addr[5:2]][8*l +: 8] <= ram_wdata[8*l +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        output logic [31:0] rd_out);
    logic        err_e;
    int          nbytes, base, ce_n, vidx;
    logic [3:0]  sel_e, sel_g;
    logic [31:0] wd_e, rd_e, v, wd_g, addr_g;
    logic        we_g;
    rd_out = 'x;
`ifdef MEM_ALIGN_CHECK_EN
    err_e = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
`else
    err_e = 1'b0;
`endif
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    base   = int'(a) / nbytes * nbytes;
    sel_e  = 4'b0000;
    for (int k = 0; k < nbytes; k++) sel_e[3 - ((base + k) % 4)] = 1'b1;
    wd_e = (sz == 2'd0) ? wd[7:0] * 32'h01010101 :
           (sz == 2'd1) ? wd[15:0] * 32'h00010001 : wd;
    v = 0;
    for (int k = 0; k < nbytes; k++) v = (v << 8) | 32'(mem_b[base + k]);
    if (sg && nbytes == 1 && v[7])  v = v | 32'hFFFFFF00;
    if (sg && nbytes == 2 && v[15]) v = v | 32'hFFFF0000;
    rd_e = (we || err_e) ? 32'h0 : v;

    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = $urandom; req_size = $urandom; req_signed = $urandom;
    req_addr = $urandom; req_wdata = $urandom;

    ce_n = 0; vidx = 0; sel_g = 0; wd_g = 0; addr_g = 0; we_g = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ram_ce) begin
        if (ce_n == 0) begin
          sel_g = ram_sel; wd_g = ram_wdata; addr_g = ram_addr; we_g = ram_we;
        end else begin
          chk("ram_stable", {ram_sel, ram_wdata[27:0]}, {sel_g, wd_g[27:0]});
        end
        ce_n++;
      end
      if (rsp_valid) begin
        vidx = i;
        break;
      end
    end
    chk("rsp_latency", vidx, err_e ? 32'd1 : 32'(WS + 2));
    chk("ce_cycles", ce_n, err_e ? 32'd0 : 32'(WS + 1));
    if (!err_e) begin
      chk("ram_sel", {28'b0, sel_g}, {28'b0, sel_e});
      chk("ram_wdata", wd_g, wd_e);
      chk("ram_addr", addr_g, 32'(base) & 32'hFFFFFFFC);
      chk("ram_we", {31'b0, we_g}, {31'b0, we});
    end
    if (vidx == 0) return;

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      req_valid = 1'b1;
      chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_ready", {31'b0, req_ready}, 32'd0);
      chk("hold_rdata", rsp_rdata, rd_e);
      chk("hold_ce", {31'b0, ram_ce}, 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("rsp_rdata", rsp_rdata, rd_e);
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, err_e});
    rd_out = rsp_rdata;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("post_valid", {31'b0, rsp_valid}, 32'd0);
    chk("post_ready", {31'b0, req_ready}, 32'd1);
    chk("post_rdata", rsp_rdata, 32'h0);

    if (we && !err_e)
      for (int k = 0; k < nbytes; k++)
        mem_b[base + k] = wd[8*(nbytes-1-k) +: 8];
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem_b[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_ram_ce", {31'b0, ram_ce}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Byte store at 0x05: lane sel 0100, replicated data, word address 0x04.
    do_req(1'b1, 2'd0, 1'b0, 32'h05, 32'h000000AB, 0, rd_got);
    // Known word then aligned loads from it.
    do_req(1'b1, 2'd2, 1'b0, 32'h00, 32'h80FF1234, 0, rd_got);
    do_req(1'b0, 2'd0, 1'b1, 32'h00, 32'h0, 0, rd_got);
    chk("ld_sb0", rd_got, 32'hFFFFFF80);
    do_req(1'b0, 2'd0, 1'b0, 32'h01, 32'h0, 0, rd_got);
    chk("ld_ub1", rd_got, 32'h000000FF);
    do_req(1'b0, 2'd1, 1'b1, 32'h02, 32'h0, 0, rd_got);
    chk("ld_sh2", rd_got, 32'h00001234);
    do_req(1'b0, 2'd2, 1'b0, 32'h00, 32'h0, 3, rd_got);
    chk("ld_w0", rd_got, 32'h80FF1234);
    // Misaligned word load: error with the check enabled, forced alignment otherwise.
    do_req(1'b0, 2'd2, 1'b0, 32'h02, 32'h0, 1, rd_got);
`ifndef MEM_ALIGN_CHECK_EN
    chk("ld_w2_forced", rd_got, 32'h80FF1234);
`endif

    // Reset during a store access: RAM strobes drop at once, no response follows.
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd2; req_addr = 32'h08; req_wdata = 32'hDEADBEEF;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_ce", {31'b0, ram_ce}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ce", {31'b0, ram_ce}, 32'd0);
    chk("arst_we", {31'b0, ram_we}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("arst_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    chk("arst_ready", {31'b0, req_ready}, 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, 0, rd_got);

    // Randomized traffic against the byte model.
    for (int t = 0; t < 150; t++)
      do_req(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 63)),
             $urandom, int'($urandom_range(0, 2)), rd_got);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
